// File: rtl/adder_pkg.sv
// Shared definitions for the adder block and its downstream stages.
package adder_pkg;

  // Default width of one adder sum.
  localparam int DEFAULT_DATA_W = 16;

  // Width of the saturating dropped-result counter.
  localparam int DROP_CNT_W = 16;

  typedef logic [DEFAULT_DATA_W-1:0] data_t;

endpackage : adder_pkg

// File: rtl/adder_result_buffer.sv
// Result buffer behind the adder: captures every valid sum into a small FIFO
// (the adder cannot be stalled) and hands sums to the consumer over
// valid/ready. Overflow drops the incoming sum and raises a sticky flag.
// Optional statistics (drop counter, peak fill) are enabled by defining
// ADDER_RESULT_BUFFER_STAT_EN; otherwise those ports read as zero.
module adder_result_buffer
  import adder_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  input  logic                       ovf_clr,
  output logic [DROP_CNT_W-1:0]      drop_cnt,
  output logic [$clog2(DEPTH):0]     peak_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level_next;
  logic              push;
  logic              pop;
  logic              drop;

  // A slot frees up in the same cycle the head leaves, so a full FIFO
  // still accepts a sum when it is popping.
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && ((level < FULL_LVL) || pop);
  assign drop      = in_valid && !push;
  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];

  // Next fill level from this cycle's push/pop pair.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the
    // output unassigned, which would infer a latch.
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  // Storage write; contents are never cleared, only the pointers are.
  always_ff @(posedge clk) begin
    // NOTE: the data array carries no reset; stale entries are unreachable
    // because level and the pointers are reset, and leaving it out keeps
    // the storage as plain flops/RAM without a reset network.
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers, fill level and sticky overflow flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_next;
      // A new drop outranks a clear issued in the same cycle.
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

`ifdef ADDER_RESULT_BUFFER_STAT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  logic [LW-1:0]         peak_q;

  // Saturating drop counter and running maximum of the registered level.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
      peak_q     <= '0;
    end else begin
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
      if (level > peak_q)             peak_q     <= level;
    end
  end

  assign drop_cnt   = drop_cnt_q;
  assign peak_level = peak_q;
`else
  assign drop_cnt   = '0;
  assign peak_level = '0;
`endif

endmodule : adder_result_buffer
